actor_fifo: RTL and testbench
=============================

ACTOR_FIFO -- requirements
Module: actor_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, token width in bits.
REQ-002 Parameter DEPTH, default 16, token capacity; power of two, 2..1024.
REQ-003 Parameter COUNT_WIDTH, default 16, width of the COUNT buses.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 In1_SEND  input  1  producer offers one token this cycle.
REQ-007 In1_DATA  input  DATA_WIDTH  offered token.
REQ-008 In1_COUNT  input  COUNT_WIDTH  producer token count; always 1, ignored.
REQ-009 In1_RDY  output  1  FIFO can accept a token this cycle.
REQ-010 In1_ACK  output  1  token accepted this cycle.
REQ-011 Out1_SEND  output  1  head token valid for the consumer.
REQ-012 Out1_DATA  output  DATA_WIDTH  head token.
REQ-013 Out1_COUNT  output  COUNT_WIDTH  tokens currently held.
REQ-014 Out1_ACK  input  1  consumer takes the head token this cycle.

Function
REQ-015 Write occurs when In1_SEND & In1_RDY; In1_ACK shall equal In1_SEND & In1_RDY combinationally.
REQ-016 In1_RDY shall be 1 iff occupancy < DEPTH and RESET is low, decoded from registered state only.
REQ-017 Read occurs when Out1_ACK & Out1_SEND; Out1_ACK while Out1_SEND=0 shall have no effect.
REQ-018 Out1_SEND shall be 1 iff occupancy > 0; Out1_DATA shall present the oldest token (first-word-fall-through), undefined when empty.
REQ-019 Latency: token written in cycle N shall be visible on Out1_SEND/Out1_DATA in cycle N+1; no same-cycle write-through when empty.
REQ-020 Occupancy: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-021 Full with Out1_ACK: In1_RDY stays 0 that cycle; the freed slot is offered in the next cycle.
REQ-022 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy register is log2(DEPTH)+1 bits.
REQ-023 Out1_COUNT shall be occupancy zero-extended to COUNT_WIDTH.
REQ-024 Token order shall be preserved across any number of pointer wraps.

Reset
REQ-025 RESET high at a clock edge shall clear pointers and occupancy; stored data is not cleared.
REQ-026 While RESET is high: In1_RDY=0, In1_ACK=0, Out1_SEND=0, Out1_COUNT=0.
REQ-027 RESET mid-operation shall discard all held tokens; the first edge with RESET low is a normal operating cycle with In1_RDY=1.

Configuration
REQ-028 Macro ACTOR_FIFO_ERR_EN defined: adds output ERR (1 bit), sticky, set the cycle after In1_SEND=1 while In1_RDY=0 with occupancy=DEPTH, or Out1_ACK=1 while Out1_SEND=0; cleared only by RESET.
REQ-029 Macro undefined: no ERR port, no associated logic; all other behaviour identical.

Structure
REQ-030 Package actor_fifo_pkg shall hold default DATA_WIDTH, DEPTH, COUNT_WIDTH constants and a clog2 function.
REQ-031 Storage shall be a sub-module actor_fifo_ram: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port.
REQ-032 Pointer, occupancy and handshake logic reside in actor_fifo.

Verification
REQ-033 Reset then idle -> In1_RDY=1, Out1_SEND=0, Out1_COUNT=0 from first edge after RESET low.
REQ-034 Write 0x11,0x22,0x33 on consecutive cycles, no ACK -> Out1_COUNT=3, Out1_DATA=0x11; three Out1_ACK cycles yield 0x11,0x22,0x33, then Out1_SEND=0.
REQ-035 Fill 16 tokens (DEPTH=16) -> In1_RDY=0, In1_ACK=0 on 17th offer; one Out1_ACK -> In1_RDY=1 next cycle, count 15.
REQ-036 Occupancy 5, In1_SEND and Out1_ACK every cycle for 40 cycles -> Out1_COUNT stays 5, output sequence equals input sequence delayed by 5 tokens across wraps.
REQ-037 Empty, In1_SEND=1 data 0xA5 and Out1_ACK=1 same cycle -> token kept, next cycle Out1_SEND=1, Out1_DATA=0xA5, Out1_COUNT=1.
REQ-038 Occupancy 7, RESET pulsed one cycle -> Out1_COUNT=0, Out1_SEND=0; with ACTOR_FIFO_ERR_EN, Out1_ACK while empty -> ERR=1 until next RESET.

Source files
------------

// File: rtl/actor_fifo_pkg.sv
// Shared defaults and helpers for the actor_fifo token buffer.
package actor_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_COUNT_WIDTH = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/actor_fifo_ram.sv
// Token storage for actor_fifo: one synchronous write port, one asynchronous read port.
module actor_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents only matter once occupancy says a slot is live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/actor_fifo.sv
// First-word-fall-through token FIFO with actor-style SEND/ACK handshakes.
// Optional sticky protocol-error output ERR when ACTOR_FIFO_ERR_EN is defined.
module actor_fifo
  import actor_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   In1_SEND,
  input  logic [DATA_WIDTH-1:0]  In1_DATA,
  input  logic [COUNT_WIDTH-1:0] In1_COUNT,
  output logic                   In1_RDY,
  output logic                   In1_ACK,
  output logic                   Out1_SEND,
  output logic [DATA_WIDTH-1:0]  Out1_DATA,
  output logic [COUNT_WIDTH-1:0] Out1_COUNT,
  input  logic                   Out1_ACK
`ifdef ACTOR_FIFO_ERR_EN
  ,
  output logic                   ERR
`endif
);

  localparam int             AW       = clog2(DEPTH);
  localparam logic [AW:0]    FULL_OCC = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          wr_en;
  logic          rd_en;

  // The producer count is always 1 and carries no information.
  logic unused_count;
  assign unused_count = ^In1_COUNT;

  // Handshakes decode only from registered state, so a read never frees a slot in the same cycle.
  assign In1_RDY    = !RESET && (occ != FULL_OCC);
  assign Out1_SEND  = !RESET && (occ != '0);
  assign In1_ACK    = In1_SEND && In1_RDY;
  assign wr_en      = In1_ACK;
  assign rd_en      = Out1_ACK && Out1_SEND;
  assign Out1_COUNT = RESET ? '0 : COUNT_WIDTH'(occ);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  actor_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk  (CLK),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(In1_DATA),
    .raddr(rd_ptr),
    .rdata(Out1_DATA)
  );

`ifdef ACTOR_FIFO_ERR_EN
  logic err_q;

  // Sticky: offer into a full FIFO, or take from an empty one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if ((In1_SEND && !In1_RDY && (occ == FULL_OCC)) || (Out1_ACK && !Out1_SEND)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`endif

endmodule

// File: tb/tb_actor_fifo.sv
// Directed self-checking bench for actor_fifo (DEPTH=16, DATA_WIDTH=8).
module tb_actor_fifo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        In1_SEND;
  logic [7:0]  In1_DATA;
  logic [15:0] In1_COUNT;
  logic        In1_RDY;
  logic        In1_ACK;
  logic        Out1_SEND;
  logic [7:0]  Out1_DATA;
  logic [15:0] Out1_COUNT;
  logic        Out1_ACK;
`ifdef ACTOR_FIFO_ERR_EN
  logic        ERR;
`endif

  int checks = 0;
  int errors = 0;

  actor_fifo dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .In1_SEND  (In1_SEND),
    .In1_DATA  (In1_DATA),
    .In1_COUNT (In1_COUNT),
    .In1_RDY   (In1_RDY),
    .In1_ACK   (In1_ACK),
    .Out1_SEND (Out1_SEND),
    .Out1_DATA (Out1_DATA),
    .Out1_COUNT(Out1_COUNT),
    .Out1_ACK  (Out1_ACK)
`ifdef ACTOR_FIFO_ERR_EN
    ,
    .ERR       (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; outputs then reflect the state committed at the last rising edge.
  task automatic drive(input logic s, input logic [7:0] d, input logic a);
    @(negedge CLK);
    In1_SEND = s;
    In1_DATA = d;
    Out1_ACK = a;
    #1;
  endtask

  initial begin
    RESET     = 1'b1;
    In1_SEND  = 1'b0;
    In1_DATA  = '0;
    In1_COUNT = 16'd1;
    Out1_ACK  = 1'b0;

    // Reset held: handshakes masked even with an offer present.
    repeat (2) @(negedge CLK);
    In1_SEND = 1'b1;
    #1;
    check("rst_rdy", In1_RDY, 0);
    check("rst_ack", In1_ACK, 0);
    check("rst_send", Out1_SEND, 0);
    check("rst_count", Out1_COUNT, 0);

    @(negedge CLK);
    RESET    = 1'b0;
    In1_SEND = 1'b0;
    #1;
    check("idle_rdy", In1_RDY, 1);
    check("idle_send", Out1_SEND, 0);
    check("idle_count", Out1_COUNT, 0);

    // Three writes, then three reads.
    drive(1, 8'h11, 0); check("w1_ack", In1_ACK, 1);
    drive(1, 8'h22, 0); check("w2_send", Out1_SEND, 1);
    drive(1, 8'h33, 0);
    drive(0, 8'h00, 0);
    check("w3_count", Out1_COUNT, 3);
    check("w3_head", Out1_DATA, 8'h11);
    drive(0, 8'h00, 1); check("r1_data", Out1_DATA, 8'h11);
    drive(0, 8'h00, 1); check("r2_data", Out1_DATA, 8'h22);
    drive(0, 8'h00, 1); check("r3_data", Out1_DATA, 8'h33);
    check("r3_count", Out1_COUNT, 1);
    drive(0, 8'h00, 0);
    check("drained_send", Out1_SEND, 0);
    check("drained_count", Out1_COUNT, 0);

    // Fill to DEPTH, refuse the 17th offer, full-with-ACK keeps RDY low for that cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'h40 + 8'(i), 0);
      check("fill_ack", In1_ACK, 1);
    end
    drive(1, 8'hEE, 0);
    check("full_rdy", In1_RDY, 0);
    check("full_ack", In1_ACK, 0);
    check("full_count", Out1_COUNT, 16);
    drive(0, 8'h00, 1);
    check("full_rd_rdy", In1_RDY, 0);
    check("full_rd_data", Out1_DATA, 8'h40);
    drive(0, 8'h00, 0);
    check("freed_rdy", In1_RDY, 1);
    check("freed_count", Out1_COUNT, 15);
    for (int i = 0; i < 15; i++) begin
      drive(0, 8'h00, 1);
      check("drain_data", Out1_DATA, 8'h41 + 8'(i));
    end
    drive(0, 8'h00, 0);
    check("drain_count", Out1_COUNT, 0);

    // Steady-state streaming at occupancy 5 across several pointer wraps.
    for (int i = 0; i < 5; i++) drive(1, 8'h80 + 8'(i), 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'h85 + 8'(i), 1);
      check("stream_count", Out1_COUNT, 5);
      check("stream_data", Out1_DATA, 8'h80 + 8'(i));
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1);
      check("stream_tail", Out1_DATA, 8'hA8 + 8'(i));
    end
    drive(0, 8'h00, 0);
    check("stream_end_count", Out1_COUNT, 0);

    // Simultaneous offer and ACK while empty: no write-through, token kept.
    drive(1, 8'hA5, 1);
    check("wt_send", Out1_SEND, 0);
    check("wt_ack", In1_ACK, 1);
    drive(0, 8'h00, 0);
    check("wt_next_send", Out1_SEND, 1);
    check("wt_next_data", Out1_DATA, 8'hA5);
    check("wt_next_count", Out1_COUNT, 1);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    check("wt_drain_count", Out1_COUNT, 0);

    // Mid-operation reset discards held tokens.
    for (int i = 0; i < 7; i++) drive(1, 8'h60 + 8'(i), 0);
    drive(0, 8'h00, 0);
    check("pre_rst_count", Out1_COUNT, 7);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("mid_rst_rdy", In1_RDY, 0);
    check("mid_rst_send", Out1_SEND, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("post_rst_count", Out1_COUNT, 0);
    check("post_rst_send", Out1_SEND, 0);
    check("post_rst_rdy", In1_RDY, 1);
    drive(1, 8'h5A, 0);
    drive(0, 8'h00, 0);
    check("post_rst_data", Out1_DATA, 8'h5A);
    check("post_rst_one", Out1_COUNT, 1);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    check("post_rst_empty", Out1_SEND, 0);

`ifdef ACTOR_FIFO_ERR_EN
    check("err_clear", ERR, 0);
    drive(0, 8'h00, 1);
    check("err_same_cycle", ERR, 0);
    drive(0, 8'h00, 0);
    check("err_set", ERR, 1);
    drive(0, 8'h00, 0);
    check("err_sticky", ERR, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("err_rst", ERR, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
